tw_mem_arbiter: RTL

//  Shares the single-port taskwait info memory (TW_MEM) between N requesters (e.g. cutoff/creation, taskwait, task-finish).

---
 rtl/tw_mem_arbiter_if.sv | 27 ++
 rtl/tw_mem_arbiter.sv | 90 +++++++++
 2 files changed

// File: rtl/tw_mem_arbiter_if.sv
// tw_mem_arbiter_if: requester-side bus of the TW_MEM arbiter.
//  req/req_en/req_we[N_REQ], req_addr/req_din packed per requester (master drives)
//  grant/rvalid[N_REQ], shared rdata (slave drives)
interface tw_mem_arbiter_if #(
    parameter int N_REQ        = 3,
    parameter int TW_MEM_BITS  = 4,
    parameter int TW_MEM_WIDTH = 101
);
    logic [N_REQ-1:0]              req;
    logic [N_REQ-1:0]              grant;
    logic [N_REQ*TW_MEM_BITS-1:0]  req_addr;
    logic [N_REQ-1:0]              req_en;
    logic [N_REQ-1:0]              req_we;
    logic [N_REQ*TW_MEM_WIDTH-1:0] req_din;
    logic [TW_MEM_WIDTH-1:0]       rdata;
    logic [N_REQ-1:0]              rvalid;

    modport master (
        output req, req_addr, req_en, req_we, req_din,
        input  grant, rdata, rvalid
    );

    modport slave (
        input  req, req_addr, req_en, req_we, req_din,
        output grant, rdata, rvalid
    );
endinterface

// File: rtl/tw_mem_arbiter.sv
// tw_mem_arbiter: round-robin, transaction-locked arbiter sharing the single-port TW_MEM.
//  clk, rstn (sync, active-low); bus: requester interface (slave side);
//  violation: sticky flag for en from a non-owner;
//  mem_addr/mem_en/mem_we/mem_din/mem_clk to TW_MEM, mem_dout from TW_MEM (1-cycle read latency).
module tw_mem_arbiter #(
    parameter int N_REQ        = 3,
    parameter int TW_MEM_BITS  = 4,
    parameter int TW_MEM_WIDTH = 101,
    parameter int IDX_BITS     = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rstn,
    tw_mem_arbiter_if.slave         bus,
    output logic                    violation,
    output logic [TW_MEM_BITS-1:0]  mem_addr,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [TW_MEM_WIDTH-1:0] mem_din,
    input  logic [TW_MEM_WIDTH-1:0] mem_dout,
    output logic                    mem_clk
);
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t              state, state_nx;
    logic [IDX_BITS-1:0] owner, last_owner, pick;
    logic                found;
    logic [N_REQ-1:0]    owner_hot, own_mask;

    assign mem_clk   = clk;
    assign bus.rdata = mem_dout;
    assign owner_hot = N_REQ'(1) << owner;
    assign own_mask  = (state == GRANT) ? owner_hot : '0;

    // First pending requester after the previous owner, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (int'(last_owner) + k) % N_REQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = IDX_BITS'(idx);
            end
        end
    end

    // Owner's request dropping ends the transaction; its en that cycle is ignored.
    always_comb begin
        state_nx = state;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        case (state)
            IDLE:    state_nx = found ? GRANT : IDLE;
            GRANT: begin
                state_nx = bus.req[owner] ? GRANT : RELEASE;
                mem_en   = bus.req[owner] && bus.req_en[owner];
                mem_we   = mem_en && bus.req_we[owner];
                mem_addr = bus.req_addr[int'(owner)*TW_MEM_BITS +: TW_MEM_BITS];
                mem_din  = bus.req_din[int'(owner)*TW_MEM_WIDTH +: TW_MEM_WIDTH];
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IDX_BITS'(N_REQ - 1);
            bus.grant  <= '0;
            bus.rvalid <= '0;
            violation  <= 1'b0;
        end else begin
            state      <= state_nx;
            bus.rvalid <= (mem_en && !mem_we) ? owner_hot : '0;
            violation  <= violation | (|(bus.req_en & ~own_mask));
            if (state == IDLE && found) begin
                owner     <= pick;
                bus.grant <= N_REQ'(1) << pick;
            end
            if (state == GRANT && !bus.req[owner]) begin
                bus.grant  <= '0;
                last_owner <= owner;
            end
        end
    end
endmodule
